// File: rtl/gcd_op_sequencer_if.sv
// gcd_op_sequencer_if: operand intake, core issue/done and result handshakes.
// master = environment side, slave = sequencer side; io_count is FIFO occupancy.
interface gcd_op_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_a;
  logic [WIDTH-1:0] io_in_b;
  logic             io_gcd_start;
  logic [WIDTH-1:0] io_gcd_a;
  logic [WIDTH-1:0] io_gcd_b;
  logic             io_gcd_done;
  logic [WIDTH-1:0] io_gcd_result;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_result;
  logic             io_out_err;
  logic [CW-1:0]    io_count;

  modport master (
    output io_in_valid, io_in_a, io_in_b,
    output io_gcd_done, io_gcd_result,
    output io_out_ready,
    input  io_in_ready, io_gcd_start,
    input  io_gcd_a, io_gcd_b,
    input  io_out_valid, io_out_result,
    input  io_out_err, io_count
  );

  modport slave (
    input  io_in_valid, io_in_a, io_in_b,
    input  io_gcd_done, io_gcd_result,
    input  io_out_ready,
    output io_in_ready, io_gcd_start,
    output io_gcd_a, io_gcd_b,
    output io_out_valid, io_out_result,
    output io_out_err, io_count
  );
endinterface

// File: rtl/gcd_op_sequencer.sv
// gcd_op_sequencer: FIFO-buffered operand feeder for a gcd core with watchdog.
// Ports: clock, reset (sync, active-low), io (slave: in/gcd/out handshakes, count).
module gcd_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 300
) (
  input  logic clock,
  input  logic reset,
  gcd_op_sequencer_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [TW-1:0]    timer;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             head_zero;

  assign io.io_in_ready = (count != CW'(DEPTH));
  assign io.io_count    = count;

  assign push      = io.io_in_valid && io.io_in_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head_a    = mem_a[rd_ptr];
  assign head_b    = mem_b[rd_ptr];
  assign head_zero = (head_a == '0) || (head_b == '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_a[wr_ptr] <= io.io_in_a;
      mem_b[wr_ptr] <= io.io_in_b;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      timer            <= '0;
      io.io_gcd_start  <= 1'b0;
      io.io_gcd_a      <= '0;
      io.io_gcd_b      <= '0;
      io.io_out_valid  <= 1'b0;
      io.io_out_result <= '0;
      io.io_out_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase

      unique case (state)
        IDLE: begin
          if (pop) begin
            if (head_zero) begin
              // gcd(0,x)=x and gcd(0,0)=0 both reduce to a|b
              io.io_out_result <= head_a | head_b;
              io.io_out_err    <= 1'b0;
              io.io_out_valid  <= 1'b1;
              state            <= DRAIN;
            end else begin
              io.io_gcd_a     <= head_a;
              io.io_gcd_b     <= head_b;
              io.io_gcd_start <= 1'b1;
              state           <= ISSUE;
            end
          end
        end
        ISSUE: begin
          io.io_gcd_start <= 1'b0;
          timer           <= '0;
          state           <= WAIT;
        end
        WAIT: begin
          if (io.io_gcd_done) begin
            io.io_out_result <= io.io_gcd_result;
            io.io_out_err    <= 1'b0;
            io.io_out_valid  <= 1'b1;
            state            <= DRAIN;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            // WAIT has lasted TIMEOUT cycles with no done
            io.io_out_result <= '0;
            io.io_out_err    <= 1'b1;
            io.io_out_valid  <= 1'b1;
            state            <= DRAIN;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DRAIN: begin
          if (io.io_out_ready) begin
            io.io_out_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_op_sequencer.sv
// tb_gcd_op_sequencer: directed bench with a queue-based reference model.
// A core model answers starts after LAT cycles unless told to hang.
module tb_gcd_op_sequencer;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;

  gcd_op_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) io ();

  gcd_op_sequencer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io(io)
  );

  always #5 clock = ~clock;

  typedef struct {
    int a;
    int b;
  } pair_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run = 0;
  bit core_hang = 0;

  pair_t mq[$];
  bit busy = 0;
  bit cur_byp = 0;
  int cur_a, cur_b;
  int pop_cyc = 0;
  int valid_from = 0;
  int exp_res = 0;
  int exp_err = 0;

  int start_cnt = 0;
  int start_a, start_b;
  int push_cyc = 0;
  int acc_cnt = 0;
  int start_q[$];
  int rise_q[$];
  int got_res[$];
  int got_err[$];
  bit prev_valid = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int gcd(int a, int b);
    int t;
    while (b != 0) begin
      t = b;
      b = a % b;
      a = t;
    end
    return a;
  endfunction

  // Reference model and per-cycle compare.
  initial forever begin
    @(negedge clock);
    cyc++;
    if (run) begin
      bit e_start, e_valid, hs, full;
      pair_t p;
      e_start = busy && !cur_byp && (cyc == pop_cyc + 1);
      e_valid = busy && (cyc >= valid_from);
      chk("count", io.io_count, mq.size());
      chk("in_ready", io.io_in_ready, mq.size() != DEPTH);
      chk("start", io.io_gcd_start, e_start);
      if (e_start) begin
        chk("gcd_a", io.io_gcd_a, cur_a);
        chk("gcd_b", io.io_gcd_b, cur_b);
      end
      chk("out_valid", io.io_out_valid, e_valid);
      if (e_valid) begin
        chk("out_result", io.io_out_result, exp_res);
        chk("out_err", io.io_out_err, exp_err);
      end

      if (io.io_gcd_start === 1'b1) begin
        start_cnt++;
        start_q.push_back(cyc);
        start_a = int'(io.io_gcd_a);
        start_b = int'(io.io_gcd_b);
      end
      if (io.io_out_valid === 1'b1 && !prev_valid) rise_q.push_back(cyc);
      prev_valid = (io.io_out_valid === 1'b1);
      if (io.io_out_valid && io.io_out_ready && reset) begin
        got_res.push_back(int'(io.io_out_result));
        got_err.push_back(int'(io.io_out_err));
      end

      if (!reset) begin
        mq.delete();
        busy = 0;
      end else begin
        hs = e_valid && io.io_out_ready;
        full = (mq.size() == DEPTH);
        if (!busy && mq.size() > 0) begin
          p = mq.pop_front();
          busy = 1;
          pop_cyc = cyc;
          cur_a = p.a;
          cur_b = p.b;
          cur_byp = (p.a == 0) || (p.b == 0);
          if (cur_byp) begin
            valid_from = cyc + 1;
            exp_res = p.a | p.b;
            exp_err = 0;
          end else if (core_hang) begin
            valid_from = cyc + TIMEOUT + 2;
            exp_res = 0;
            exp_err = 1;
          end else begin
            valid_from = cyc + LAT + 2;
            exp_res = gcd(p.a, p.b);
            exp_err = 0;
          end
        end else if (hs) begin
          busy = 0;
        end
        if (io.io_in_valid && !full) begin
          p.a = int'(io.io_in_a);
          p.b = int'(io.io_in_b);
          mq.push_back(p);
          push_cyc = cyc;
          acc_cnt++;
        end
      end
    end
  end

  // Core model: done pulse LAT cycles after start, unless hanging.
  initial begin
    io.io_gcd_done = 1'b0;
    io.io_gcd_result = '0;
    forever begin
      @(negedge clock);
      if (run && io.io_gcd_start === 1'b1 && !core_hang) begin
        int r;
        r = gcd(int'(io.io_gcd_a), int'(io.io_gcd_b));
        repeat (LAT) @(posedge clock);
        #2;
        io.io_gcd_done = 1'b1;
        io.io_gcd_result = WIDTH'(r);
        @(posedge clock);
        #2;
        io.io_gcd_done = 1'b0;
        io.io_gcd_result = '0;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic push(int a, int b);
    bit ok;
    ok = 0;
    io.io_in_valid = 1'b1;
    io.io_in_a = WIDTH'(a);
    io.io_in_b = WIDTH'(b);
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clock);
      ok = io.io_in_ready;
      @(posedge clock);
      #2;
    end
    io.io_in_valid = 1'b0;
    if (!ok) chk("push_accept", ok, 1);
  endtask

  task automatic wait_results(int n);
    int k;
    k = 0;
    while (got_res.size() < n && k < 1000) begin
      tick(1);
      k++;
    end
    if (got_res.size() < n) chk("result_timeout", got_res.size(), n);
  endtask

  task automatic wait_starts(int n);
    int k;
    k = 0;
    while (start_cnt < n && k < 1000) begin
      tick(1);
      k++;
    end
    if (start_cnt < n) chk("start_timeout", start_cnt, n);
  endtask

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int a2[6] = '{12, 9, 35, 8, 21, 50};
  int b2[6] = '{18, 6, 14, 12, 14, 75};
  int r2[5] = '{6, 3, 7, 4, 7};

  initial begin
    int s0, n0, a0, r0, st0, k;
    io.io_in_valid = 1'b0;
    io.io_in_a = '0;
    io.io_in_b = '0;
    io.io_out_ready = 1'b0;

    // Reset state
    tick(2);
    run = 1;
    chk("rst_start", io.io_gcd_start, 0);
    chk("rst_valid", io.io_out_valid, 0);
    chk("rst_result", io.io_out_result, 0);
    chk("rst_err", io.io_out_err, 0);
    chk("rst_gcd_a", io.io_gcd_a, 0);
    chk("rst_gcd_b", io.io_gcd_b, 0);
    chk("rst_count", io.io_count, 0);
    chk("rst_in_ready", io.io_in_ready, 1);
    reset = 1'b1;
    tick(2);

    // 1: single core operation
    io.io_out_ready = 1'b1;
    s0 = start_cnt;
    n0 = got_res.size();
    r0 = rise_q.size();
    st0 = start_q.size();
    push(12, 18);
    wait_results(n0 + 1);
    chk("t1_starts", start_cnt - s0, 1);
    chk("t1_start_a", start_a, 12);
    chk("t1_start_b", start_b, 18);
    if (got_res.size() > n0) begin
      chk("t1_res", got_res[n0], 6);
      chk("t1_err", got_err[n0], 0);
    end
    if (rise_q.size() > r0 && start_q.size() > st0) begin
      chk("t1_start_lat", start_q[st0] - push_cyc, 2);
      chk("t1_done_lat", rise_q[r0] - start_q[st0], LAT + 1);
    end
    tick(3);

    // 2: fill FIFO with the consumer stalled
    io.io_out_ready = 1'b0;
    n0 = got_res.size();
    a0 = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      io.io_in_valid = 1'b1;
      io.io_in_a = WIDTH'(a2[i]);
      io.io_in_b = WIDTH'(b2[i]);
      tick(1);
    end
    io.io_in_valid = 1'b0;
    chk("t2_accepted", acc_cnt - a0, 5);
    chk("t2_count_full", io.io_count, DEPTH);
    chk("t2_in_ready", io.io_in_ready, 0);
    tick(3);
    io.io_out_ready = 1'b1;
    wait_results(n0 + 5);
    for (int i = 0; i < 5; i++) begin
      if (got_res.size() > n0 + i) begin
        chk("t2_res", got_res[n0 + i], r2[i]);
        chk("t2_err", got_err[n0 + i], 0);
      end
    end
    tick(3);

    // 3: zero-operand bypass
    s0 = start_cnt;
    n0 = got_res.size();
    r0 = rise_q.size();
    push(0, 25);
    k = push_cyc;
    push(0, 0);
    wait_results(n0 + 2);
    tick(2);
    chk("t3_no_start", start_cnt - s0, 0);
    if (got_res.size() > n0 + 1) begin
      chk("t3_res0", got_res[n0], 25);
      chk("t3_res1", got_res[n0 + 1], 0);
    end
    if (rise_q.size() > r0) chk("t3_lat", rise_q[r0] - k, 2);

    // 4: watchdog timeout, then normal issue
    core_hang = 1;
    s0 = start_cnt;
    n0 = got_res.size();
    r0 = rise_q.size();
    st0 = start_q.size();
    push(6, 4);
    push(10, 15);
    wait_starts(s0 + 1);
    core_hang = 0;
    wait_results(n0 + 2);
    chk("t4_starts", start_cnt - s0, 2);
    if (got_res.size() > n0 + 1) begin
      chk("t4_res_to", got_res[n0], 0);
      chk("t4_err_to", got_err[n0], 1);
      chk("t4_res_ok", got_res[n0 + 1], 5);
      chk("t4_err_ok", got_err[n0 + 1], 0);
    end
    if (rise_q.size() > r0 && start_q.size() > st0)
      chk("t4_to_lat", rise_q[r0] - start_q[st0], TIMEOUT + 1);
    tick(8);

    // 5: reset while waiting with two pairs queued
    n0 = got_res.size();
    push(12, 18);
    push(9, 6);
    push(35, 14);
    tick(1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    s0 = start_cnt;
    chk("t5_count", io.io_count, 0);
    chk("t5_start", io.io_gcd_start, 0);
    chk("t5_valid", io.io_out_valid, 0);
    chk("t5_in_ready", io.io_in_ready, 1);
    tick(12);
    chk("t5_no_result", got_res.size(), n0);
    chk("t5_no_start", start_cnt, s0);

    // 6: result held while consumer stalls
    io.io_out_ready = 1'b0;
    s0 = start_cnt;
    n0 = got_res.size();
    r0 = rise_q.size();
    push(8, 12);
    k = 0;
    while (rise_q.size() == r0 && k < 100) begin
      tick(1);
      k++;
    end
    chk("t6_valid_seen", rise_q.size() > r0, 1);
    push(9, 6);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t6_hold_res", io.io_out_result, 4);
      chk("t6_hold_err", io.io_out_err, 0);
    end
    chk("t6_one_start", start_cnt - s0, 1);
    io.io_out_ready = 1'b1;
    wait_results(n0 + 2);
    chk("t6_two_starts", start_cnt - s0, 2);
    if (got_res.size() > n0 + 1) begin
      chk("t6_res0", got_res[n0], 4);
      chk("t6_res1", got_res[n0 + 1], 3);
    end
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
